// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding and the reset PC default.
package mips_pkg;

    localparam logic [5:0]  JOPCODE      = 6'b000010;
    localparam logic [5:0]  BEQOPCODE    = 6'b000100;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        VALID = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch stage: jump, taken branch, or sequential.
module pc_next_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       instr_idx,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] branch_target;

    assign jump_target   = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};
    assign branch_off    = {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
    // Wraps modulo 2^ADDR_W; no overflow trap on branch targets.
    assign branch_target = pc_plus4 + branch_off;

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = jump_target;
        else if (branch && zero)
            next_pc = branch_target;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory over req/ready and presents the word with valid/accept.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              CLK,
    input  logic              Reset_L,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemReady,
    input  logic [31:0]       ImemData,
    output logic [31:0]       Instruction,
    output logic [5:0]        Opcode,
    output logic [5:0]        FuncCode,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              InstrValid,
    input  logic              InstrAccept,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Zero
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [31:0]       instr;
    logic              accept;
    logic              capture;

    assign accept  = (state == VALID) && InstrAccept && !Stall;
    assign capture = (state == REQ) && ImemReady;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc_plus4  (PCPlus4),
        .instr_idx (instr[25:0]),
        .branch    (Branch),
        .jump      (Jump),
        .zero      (Zero),
        .next_pc   (next_pc)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept)
                pc <= next_pc;
            if (capture)
                instr <= ImemData;
        end
    end

    // Outputs are pure functions of state so consumers see no input-to-output paths.
    always_comb begin
        state_nxt  = state;
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                ImemReq = 1'b1;
                if (ImemReady)
                    state_nxt = VALID;
            end
            VALID: begin
                InstrValid = 1'b1;
                if (accept)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ImemAddr    = pc;
    assign PCPlus4     = pc + ADDR_W'(4);
    assign Instruction = instr;
    assign Opcode      = instr[31:26];
    assign FuncCode    = instr[5:0];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the single-cycle control decoder. It holds the PC, requests instruction words from instruction memory over a req/ready handshake, and presents the fetched word with a valid/accept handshake. It splits the word into Opcode/FuncCode for the decoder. On accept, it computes the next PC from the decoder's Branch/Jump outputs and the ALU Zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (must be word aligned)
ADDR_W, 32, PC and instruction-memory address width

Ports:
CLK  in  1  single clock, rising edge
Reset_L  in  1  asynchronous, active-low reset
ImemReq  out  1  read request to instruction memory
ImemAddr  out  ADDR_W  word-aligned fetch address (equals PC)
ImemReady  in  1  memory response strobe; ImemData valid in the same cycle
ImemData  in  32  instruction word
Instruction  out  32  registered instruction word
Opcode  out  6  Instruction[31:26], to decoder
FuncCode  out  6  Instruction[5:0], to decoder
PCPlus4  out  ADDR_W  PC+4 of the presented instruction
InstrValid  out  1  Instruction/Opcode/FuncCode/PCPlus4 are valid
InstrAccept  in  1  consumer retires the presented instruction this cycle
Stall  in  1  suppresses acceptance; overrides InstrAccept
Branch  in  1  decoder Branch; sampled on the accept cycle
Jump  in  1  decoder Jump; sampled on the accept cycle
Zero  in  1  ALU zero flag; sampled on the accept cycle

Behaviour:
- Reset (asynchronous, Reset_L=0): state=IDLE, PC=RESET_PC, ImemReq=0, InstrValid=0, Instruction=32'h0, PCPlus4=RESET_PC+4.
  - Instruction=0 decodes to sll $0,$0,0, which is harmless. Downstream still gates RegWrite/MemWrite with InstrValid.
  - A memory response that arrives during or after reset while in IDLE is ignored.
- FSM states: IDLE, REQ, VALID.
  - IDLE -> REQ: unconditionally, one cycle after reset deassertion.
  - REQ: ImemReq=1, ImemAddr=PC. If ImemReady=1 in this cycle, capture ImemData into Instruction and go to VALID. Otherwise stay in REQ, with address and request held stable.
  - VALID: ImemReq=0, InstrValid=1. Accept occurs when InstrAccept=1 and Stall=0. On accept, PC=next_pc, Instruction is held, and the state goes to REQ. Otherwise stay in VALID with all outputs stable.
- Accepting on the first VALID cycle is legal.
- Minimum throughput is one instruction per 2 cycles, given a zero-wait memory.
- InstrValid=0 in IDLE and REQ. Instruction keeps its last value but must not be consumed.
- next_pc, evaluated on the accept cycle. Priority is Jump, then Branch&Zero, then sequential:
  - Jump=1: {PCPlus4[31:28], Instruction[25:0], 2'b00}
  - Branch=1 and Zero=1: PCPlus4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00}, modulo 2^ADDR_W (wrap-around permitted, no trap)
  - otherwise: PCPlus4
- Branch and Jump both 1 (illegal decode): Jump wins.
- PCPlus4 = PC+4 modulo 2^ADDR_W. PC 32'hFFFF_FFFC wraps to 0.
- Branch, Jump and Zero are ignored outside the accept cycle.
- Unknown opcodes are passed through unchanged. The decoder's default case handles them.
- Stall held high indefinitely keeps the unit in VALID with no memory traffic.
- Async reset while in REQ with ImemReady pending: the request drops immediately and PC returns to RESET_PC.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: JOPCODE=6'b000010, BEQOPCODE=6'b000100 (also used by the decoder)
  - fetch FSM state encoding: IDLE=2'b00, REQ=2'b01, VALID=2'b10
  - RESET_PC default
- One natural sub-module: pc_next_calc. It is combinational and takes PCPlus4, Instruction[25:0], Branch, Jump and Zero, and produces next_pc.
- The FSM and registers stay in instruction_fetch_unit.

Test Plan:
- Reset release, zero-wait memory returning 32'h2008_0005 (addi): ImemReq=1 with ImemAddr=0 in cycle 2. InstrValid=1 in cycle 3 with Opcode=6'b001000 and PCPlus4=4. Accept -> next ImemAddr=4.
- Memory wait states: ImemReady low for 3 REQ cycles. ImemReq and ImemAddr stay stable, InstrValid=0 throughout. Word is captured on the 4th cycle.
- Taken beq at PC=0x10, Instruction=32'h1000_FFFC, Branch=1, Zero=1, accept -> next ImemAddr=0x04. Same instruction with Zero=0 -> next ImemAddr=0x14.
- Jump at PC=0x4000_0008, Instruction=32'h0800_0100, Jump=1 -> next ImemAddr=0x4000_0400. With Branch=1 and Zero=1 also set -> still 0x4000_0400.
- Stall=1 with InstrAccept=1 for 5 cycles: stays in VALID, ImemReq=0, outputs unchanged. Stall drops -> accepted and the next fetch is issued.
- Reset_L pulsed low mid-REQ at PC=0x20: outputs return to reset values asynchronously. After release, the first fetch address is RESET_PC. A late ImemReady is ignored.
